// File: rtl/fifo_flags.sv
// Synchronous first-word-fall-through FIFO with arbitrary depth, fill level,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module fifo_flags #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 5,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  enQ,
    input  logic                  deQ,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_WIDTH-1:0]  L_DEPTH = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  L_AF    = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0]  L_AE    = CNT_WIDTH'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] L_LAST  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_deq_ok;
    logic                  w_enq_ok;
    logic [ADDR_WIDTH-1:0] w_wr_next;
    logic [ADDR_WIDTH-1:0] w_rd_next;

    // A dequeue frees a slot in the same cycle, so a full FIFO still accepts enQ with deQ.
    assign w_deq_ok = deQ & (r_count != '0);
    assign w_enq_ok = enQ & ((r_count != L_DEPTH) | w_deq_ok);

    // Pointers wrap at DEPTH-1, which need not be a power of two.
    assign w_wr_next = (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
    assign w_rd_next = (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_ok) r_wr_ptr <= w_wr_next;
            if (w_deq_ok) r_rd_ptr <= w_rd_next;
            if (w_enq_ok && !w_deq_ok) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (w_deq_ok && !w_enq_ok) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && !flush && w_enq_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // A new error in the same cycle as clr_err wins; flush leaves the flags alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            if (clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
        end else begin
            if (enQ && !w_enq_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (deQ && !w_deq_ok) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign data_out     = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign empty        = (r_count == '0);
    assign full         = (r_count == L_DEPTH);
    assign almost_empty = (r_count <= L_AE);
    assign almost_full  = (r_count >= L_AF);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_fifo_flags;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned AF    = 5;
    localparam int unsigned AE    = 1;

    logic          clock = 1'b0;
    logic          reset, flush, clr_err, enQ, deQ;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty, full, almost_empty, almost_full;
    logic [2:0]    count;
    logic          overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_q [$];
    bit            m_ov = 1'b0;
    bit            m_un = 1'b0;

    fifo_flags #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(3),
        .CNT_WIDTH (3),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .clr_err     (clr_err),
        .enQ         (enQ),
        .deQ         (deQ),
        .data_in     (data_in),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = m_q.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("data_out", 32'(data_out), (n != 0) ? 32'(m_q[0]) : 32'h0);
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("full", 32'(full), 32'(n == DEPTH));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
        check_eq("overflow", 32'(overflow), 32'(m_ov));
        check_eq("underflow", 32'(underflow), 32'(m_un));
    endtask

    // One clock: drive inputs, advance the reference model at the edge, check after it.
    task automatic cycle(input bit r, input bit f, input bit c, input bit e, input bit d,
                         input logic [DW-1:0] din);
        bit dq_ok, eq_ok;
        reset = r; flush = f; clr_err = c; enQ = e; deQ = d; data_in = din;
        @(posedge clock);
        if (r) begin
            m_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else if (f) begin
            m_q.delete();
            if (c) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
        end else begin
            dq_ok = d && (m_q.size() != 0);
            eq_ok = e && ((m_q.size() != DEPTH) || dq_ok);
            if (c) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            if (e && !eq_ok) m_ov = 1'b1;
            if (d && !dq_ok) m_un = 1'b1;
            if (dq_ok) void'(m_q.pop_front());
            if (eq_ok) m_q.push_back(din);
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [DW-1:0] drain_exp [6];
        bit r, f, c, e, d;
        int unsigned bias;
        drain_exp = '{8'h14, 8'h15, 8'h16, 8'h77, 8'h77, 8'h77};

        reset = 1'b1; flush = 1'b0; clr_err = 1'b0; enQ = 1'b0; deQ = 1'b0; data_in = '0;
        cycle(1, 0, 0, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 0, 8'h00);
        check_eq("reset_empty", 32'(empty), 32'd1);
        check_eq("reset_data_out", 32'(data_out), 32'd0);

        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 1, 0, DW'(8'h11 + i));
            check_eq("fill_head", 32'(data_out), 32'h11);
        end
        check_eq("fill_full", 32'(full), 32'd1);

        cycle(0, 0, 0, 1, 0, 8'h77);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd6);
        cycle(0, 0, 1, 0, 0, 8'h00);
        check_eq("ovf_clr", 32'(overflow), 32'd0);

        for (int i = 0; i < 3; i++) begin
            check_eq("full_swap_head", 32'(data_out), 32'(8'h11 + i));
            cycle(0, 0, 0, 1, 1, 8'h77);
            check_eq("full_swap_full", 32'(full), 32'd1);
        end
        check_eq("full_swap_next", 32'(data_out), 32'h14);

        for (int i = 0; i < 6; i++) begin
            check_eq("drain_order", 32'(data_out), 32'(drain_exp[i]));
            cycle(0, 0, 0, 0, 1, 8'h00);
        end
        check_eq("drain_empty", 32'(empty), 32'd1);

        cycle(0, 0, 0, 1, 1, 8'hA5);
        check_eq("empty_swap_unf", 32'(underflow), 32'd1);
        check_eq("empty_swap_dout", 32'(data_out), 32'hA5);

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, DW'(8'h40 + i));
        check_eq("pre_flush_count", 32'(count), 32'd4);
        cycle(0, 1, 0, 1, 0, 8'hEE);
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_dout", 32'(data_out), 32'd0);
        check_eq("flush_keeps_unf", 32'(underflow), 32'd1);

        cycle(0, 0, 0, 1, 0, 8'h51);
        cycle(0, 0, 0, 1, 0, 8'h52);
        cycle(1, 0, 0, 1, 1, 8'h53);
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_unf", 32'(underflow), 32'd0);
        cycle(0, 0, 0, 1, 0, 8'h3C);
        check_eq("midrst_dout", 32'(data_out), 32'h3C);
        cycle(0, 0, 0, 0, 1, 8'h00);
        check_eq("midrst_drained", 32'(empty), 32'd1);

        // Random traffic; the enQ/deQ bias drifts so the FIFO visits both full and empty.
        for (int i = 0; i < 3000; i++) begin
            bias = ((i / 200) % 2 == 0) ? 75 : 25;
            r = ($urandom_range(99) == 0);
            f = ($urandom_range(49) == 0);
            c = !f && ($urandom_range(19) == 0);
            e = ($urandom_range(99) < bias);
            d = ($urandom_range(99) < 100 - bias);
            cycle(r, f, c, e, d, DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
